dmem_responder: RTL and testbench

//   Memory-side responder for the load/store queue request channel. It accepts tagged

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_req_fifo.sv | 54 +++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the dmem_responder backing store.
package dmem_pkg;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned ID_W      = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // addr holds the word index; byte offset and upper address bits are dropped at accept
  typedef struct packed {
    logic              rw;
    logic [IDX_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } req_t;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue with registered occupancy count.
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output req_t                     head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  req_t          entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = entries[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed backing store answering tagged LSQ requests in order.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LAT    = 3,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              rw_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_in,
  input  logic [ID_W-1:0]   ldstID_in,
  output logic              stall_out,
  output logic [31:0]       data_out,
  output logic [ID_W-1:0]   ldstID_out,
  output logic              ready_out
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  req_t               svc_q;
  logic [DATA_W-1:0]  mem [MEM_WORDS];

  req_t               in_req;
  req_t               fifo_head_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic [CW-1:0]      fifo_count;

  logic               accept_c;
  logic               next_avail_c;
  logic               do_access_c;
  logic               load_c;
  logic               fifo_push_c;
  logic               fifo_pop_c;
  req_t               next_req_c;
  logic               unused_bits;

  assign in_req = '{rw: rw_in, addr: addr_in[IDX_W+1:2], data: data_in, id: ldstID_in};
  assign unused_bits = ^{addr_in[31:IDX_W+2], addr_in[1:0], fifo_full_c};

  assign stall_out    = (fifo_count == CW'(QDEPTH));
  assign accept_c     = valid_in && !stall_out;
  assign next_avail_c = !fifo_empty_c || accept_c;

  dmem_req_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_c),
    .push_data (in_req),
    .pop       (fifo_pop_c),
    .head_c    (fifo_head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (next_avail_c) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = next_avail_c ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An empty queue lets the accepted request go straight into service so an idle
  // unit answers LAT cycles after acceptance; otherwise the queue head is taken.
  always_comb begin
    do_access_c = 1'b0;
    load_c      = 1'b0;
    fifo_pop_c  = 1'b0;
    fifo_push_c = 1'b0;
    next_req_c  = fifo_empty_c ? in_req : fifo_head_c;
    case (state_q)
      IDLE:    load_c = next_avail_c;
      ACCESS:  begin
        do_access_c = (cnt_q == '0);
        load_c      = do_access_c && next_avail_c;
      end
      default: load_c = 1'b0;
    endcase
    fifo_pop_c  = load_c && !fifo_empty_c;
    fifo_push_c = accept_c && !(load_c && fifo_empty_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      svc_q <= '0;
    end else if (load_c) begin
      cnt_q <= CNT_W'(LAT - 1);
      svc_q <= next_req_c;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Array contents survive reset; a reset edge cancels the access in flight.
  always_ff @(posedge clk) begin
    if (!rst && do_access_c && svc_q.rw) mem[svc_q.addr] <= svc_q.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_out  <= 1'b0;
      data_out   <= '0;
      ldstID_out <= '0;
    end else begin
      ready_out <= do_access_c;
      if (do_access_c) begin
        ldstID_out <= svc_q.id;
        data_out   <= svc_q.rw ? svc_q.data : mem[svc_q.addr];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single requests plus multi-cycle sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned LAT    = 3;
  localparam int unsigned QDEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic            rw_in;
  logic [31:0]     addr_in;
  logic [31:0]     data_in;
  logic [ID_W-1:0] ldstID_in;
  logic            stall_out;
  logic [31:0]     data_out;
  logic [ID_W-1:0] ldstID_out;
  logic            ready_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            rw;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic [31:0]     exp_data;
  } vec_t;

  vec_t            vecs [11];
  vec_t            final_rd;
  int              np;
  int              pe  [16];
  logic [31:0]     pd  [16];
  logic [ID_W-1:0] pid [16];
  int              acc_edge [8];
  int              acc_exp  [8] = '{0, 1, 2, 3, 4, 5, 7, 10};
  logic            stall_exp [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
  int              nxt;
  logic            st_before;
  int              seen;

  always #5 clk = ~clk;

  dmem_responder #(
    .LAT    (LAT),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .rw_in      (rw_in),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .ldstID_in  (ldstID_in),
    .stall_out  (stall_out),
    .data_out   (data_out),
    .ldstID_out (ldstID_out),
    .ready_out  (ready_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [ID_W-1:0] id);
    valid_in  = 1'b1;
    rw_in     = rw;
    addr_in   = a;
    data_in   = d;
    ldstID_in = id;
  endtask

  task automatic idle_in();
    valid_in  = 1'b0;
    rw_in     = 1'b0;
    addr_in   = '0;
    data_in   = '0;
    ldstID_in = '0;
  endtask

  // one request into an idle, empty unit; checks latency, tag, data and pulse width
  task automatic run_one(input vec_t v, input string nm);
    int lat;
    lat = 0;
    chk({nm, "_stall"}, 32'(stall_out), 32'd0);
    drive(v.rw, v.addr, v.data, v.id);
    tick();
    idle_in();
    chk({nm, "_rdy_at_accept"}, 32'(ready_out), 32'd0);
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      tick();
      if (ready_out) lat = j;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_id"}, 32'(ldstID_out), 32'(v.id));
    chk({nm, "_data"}, data_out, v.exp_data);
    tick();
    chk({nm, "_pulse_end"}, 32'(ready_out), 32'd0);
    chk({nm, "_hold"}, data_out, v.exp_data);
  endtask

  task automatic record(input int e);
    if (ready_out) begin
      if (np < 16) begin
        pe[np]  = e;
        pd[np]  = data_out;
        pid[np] = ldstID_out;
      end
      np++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'd44,         32'h0000_1234, 4'd2,  32'h0000_1234};
    vecs[1]  = '{1'b0, 32'd44,         32'h0,         4'd3,  32'h0000_1234};
    vecs[2]  = '{1'b1, 32'd0,          32'h0000_0055, 4'd4,  32'h0000_0055};
    vecs[3]  = '{1'b0, 32'd4096,       32'h0,         4'd5,  32'h0000_0055};
    vecs[4]  = '{1'b0, 32'd4097,       32'h0,         4'd6,  32'h0000_0055};
    vecs[5]  = '{1'b1, 32'h0000_0FFC,  32'hDEAD_BEEF, 4'd7,  32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_1FFC,  32'h0,         4'd8,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'd8,          32'h0000_A5A5, 4'd9,  32'h0000_A5A5};
    vecs[8]  = '{1'b0, 32'hFFFF_0008,  32'h1234_5678, 4'd10, 32'h0000_A5A5};
    vecs[9]  = '{1'b1, 32'h0000_0300,  32'h0000_1111, 4'd11, 32'h0000_1111};
    vecs[10] = '{1'b0, 32'h0000_0303,  32'h0,         4'd12, 32'h0000_1111};
    final_rd = '{1'b0, 32'h0000_0300,  32'h0,         4'd13, 32'h0000_1111};

    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 32'(ready_out), 32'd0);
    chk("reset_data", data_out, 32'd0);
    chk("reset_id", 32'(ldstID_out), 32'd0);
    chk("reset_stall", 32'(stall_out), 32'd0);

    for (int i = 0; i < 11; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // write then read same word back to back: pulses LAT apart, read sees new data
    drive(1'b1, 32'd40, 32'd9000, 4'd1);
    tick();
    drive(1'b0, 32'd40, 32'd0, 4'd3);
    tick();
    idle_in();
    np = 0;
    for (int e = 2; e <= 9; e++) begin
      tick();
      record(e);
    end
    chk("raw_count", 32'(np), 32'd2);
    chk("raw_edge0", 32'(pe[0]), 32'd3);
    chk("raw_id0", 32'(pid[0]), 32'd1);
    chk("raw_data0", pd[0], 32'd9000);
    chk("raw_edge1", 32'(pe[1]), 32'd6);
    chk("raw_id1", 32'(pid[1]), 32'd3);
    chk("raw_data1", pd[1], 32'd9000);
    chk("raw_hold_id", 32'(ldstID_out), 32'd3);

    // valid held through back-pressure: stall pattern, accept edges, in-order completions
    np  = 0;
    nxt = 0;
    for (int e = 0; e <= 10; e++) begin
      if (nxt < 8) drive(1'b1, 32'h200 + 32'(4 * nxt), 32'h1000 + 32'(nxt), 4'(nxt));
      else         idle_in();
      st_before = stall_out;
      tick();
      if (nxt < 8 && !st_before) begin
        acc_edge[nxt] = e;
        nxt++;
      end
      record(e);
      chk($sformatf("stall_e%0d", e), 32'(stall_out), 32'(stall_exp[e]));
    end
    idle_in();
    for (int e = 11; e <= 30; e++) begin
      tick();
      record(e);
    end
    chk("bp_accepted", 32'(nxt), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_acc_edge%0d", i), 32'(acc_edge[i]), 32'(acc_exp[i]));
    chk("bp_pulses", 32'(np), 32'd8);
    for (int i = 0; i < 8 && i < np; i++) begin
      chk($sformatf("bp_edge%0d", i), 32'(pe[i]), 32'(3 + 3 * i));
      chk($sformatf("bp_id%0d", i), 32'(pid[i]), 32'(i));
      chk($sformatf("bp_data%0d", i), pd[i], 32'h1000 + 32'(i));
    end
    chk("bp_drained_stall", 32'(stall_out), 32'd0);

    // reset while a write to 0x300 is at its access edge with two reads queued
    drive(1'b1, 32'h300, 32'h2222, 4'd1);
    tick();
    drive(1'b0, 32'h300, 32'h0, 4'd2);
    tick();
    drive(1'b0, 32'h304, 32'h0, 4'd3);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_id", 32'(ldstID_out), 32'd0);
    seen = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (ready_out) seen++;
    end
    chk("rst_no_pulses", 32'(seen), 32'd0);
    run_one(final_rd, "rst_word_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
